hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 168 ++++++++++++++++
 tb/tb_hazard_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard controller for a 5-stage in-order pipeline.
// Detects load-use hazards, applies redirect flushes, selects EX operand
// forwarding sources, and drains and freezes the pipeline on an external
// 4-phase halt request.
module hazard_controller #(
   parameter int REGADDR_W   = 5,
   parameter int DRAIN_DEPTH = 4   // legal range 1..15
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   // decode stage
   input  logic [REGADDR_W-1:0] i_id_rs1,
   input  logic [REGADDR_W-1:0] i_id_rs2,
   input  logic                 i_id_use_rs1,
   input  logic                 i_id_use_rs2,
   // execute stage
   input  logic [REGADDR_W-1:0] i_ex_rd,
   input  logic                 i_ex_regwrite,
   input  logic                 i_ex_is_load,
   input  logic                 i_ex_redirect,
   input  logic [REGADDR_W-1:0] i_ex_rs1,
   input  logic [REGADDR_W-1:0] i_ex_rs2,
   // memory stage
   input  logic [REGADDR_W-1:0] i_mem_rd,
   input  logic                 i_mem_regwrite,
   // writeback stage
   input  logic [REGADDR_W-1:0] i_wb_rd,
   input  logic                 i_wb_regwrite,
   // halt handshake
   input  logic                 i_halt_req,
   output logic                 o_halt_ack,
   // pipeline control
   output logic                 o_pc_en,
   output logic                 o_dbuf_en,
   output logic                 o_dbuf_flush,
   output logic                 o_ebuf_flush,
   output logic [1:0]           o_fwd_rs1,
   output logic [1:0]           o_fwd_rs2,
   output logic [1:0]           o_state
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   localparam logic [3:0] C_DEPTH = 4'(DRAIN_DEPTH);

   // forwarding select codes
   localparam logic [1:0] FWD_BUF = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_halt_ack;
   logic       w_lu;

   // Register x0 is hardwired zero, so a write to it is never a real producer.
   assign w_lu = i_ex_is_load && i_ex_regwrite && (i_ex_rd != '0) &&
                 ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                  (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

   function automatic logic [1:0] fwd_sel(
      input logic [REGADDR_W-1:0] rs,
      input logic [REGADDR_W-1:0] mem_rd,
      input logic                 mem_wr,
      input logic [REGADDR_W-1:0] wb_rd,
      input logic                 wb_wr
   );
      // MEM holds the younger result, so it wins over WB.
      if (mem_wr && (mem_rd != '0) && (mem_rd == rs))
         return FWD_MEM;
      else if (wb_wr && (wb_rd != '0) && (wb_rd == rs))
         return FWD_WB;
      else
         return FWD_BUF;
   endfunction

   // Operand source selection for both EX operands.
   always_comb begin
      o_fwd_rs1 = fwd_sel(i_ex_rs1, i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite);
      o_fwd_rs2 = fwd_sel(i_ex_rs2, i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite);
   end

   // Stall / flush / fetch-enable decode from state and current hazards.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      o_pc_en      = 1'b1;
      o_dbuf_en    = 1'b1;
      o_dbuf_flush = 1'b0;
      o_ebuf_flush = 1'b0;
      if (r_state == ST_HALTED) begin
         // frozen: keep feeding bubbles, redirects are ignored
         o_pc_en      = 1'b0;
         o_dbuf_flush = 1'b1;
      end else if (i_ex_redirect) begin
         // squash the two wrong-path instructions, fetch from the new target
         o_dbuf_flush = 1'b1;
         o_ebuf_flush = 1'b1;
      end else if (w_lu) begin
         // hold PC and decode, insert a bubble into EX for one cycle
         o_pc_en      = 1'b0;
         o_dbuf_en    = 1'b0;
         o_ebuf_flush = 1'b1;
      end else if (r_state == ST_DRAIN) begin
         // stop fetching; decode receives bubbles while the pipe empties
         o_pc_en      = 1'b0;
         o_dbuf_flush = 1'b1;
      end
   end

   // Halt FSM with drain counter and registered acknowledge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!i_rst_n) begin
         r_state    <= ST_RUN;
         r_cnt      <= '0;
         r_halt_ack <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               // a redirect this cycle postpones drain entry by one cycle
               if (i_halt_req && !i_ex_redirect) begin
                  r_state <= ST_DRAIN;
                  r_cnt   <= C_DEPTH;
               end
            end
            ST_DRAIN: begin
               if (!i_halt_req) begin
                  // request withdrawn: resume fetching at the held PC
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
               end else if (i_ex_redirect) begin
                  // new instructions may follow the redirect target; restart drain
                  r_cnt <= C_DEPTH;
               end else if (!w_lu) begin
                  if (r_cnt == 4'd1) begin
                     r_state    <= ST_HALTED;
                     r_cnt      <= '0;
                     r_halt_ack <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - 4'd1;
                  end
               end
            end
            ST_HALTED: begin
               if (!i_halt_req) begin
                  r_state    <= ST_RUN;
                  r_halt_ack <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_RUN;
               r_cnt      <= '0;
               r_halt_ack <= 1'b0;
            end
         endcase
      end
   end

   assign o_halt_ack = r_halt_ack;
   assign o_state    = r_state;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the rules.
module tb_hazard_controller;

   localparam int RW    = 5;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [RW-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
   logic          id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, ex_redirect;
   logic          mem_regwrite, wb_regwrite, halt_req;
   logic          halt_ack, pc_en, dbuf_en, dbuf_flush, ebuf_flush;
   logic [1:0]    fwd_rs1, fwd_rs2, state;

   int n_checks = 0;
   int n_pass   = 0;

   // model: 0 running, 1 draining, 2 halted; m_left = drain cycles still owed
   int m_mode = 0;
   int m_left = 0;

   hazard_controller #(.REGADDR_W(RW), .DRAIN_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
      .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite), .i_ex_is_load(ex_is_load),
      .i_ex_redirect(ex_redirect), .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
      .i_mem_rd(mem_rd), .i_mem_regwrite(mem_regwrite),
      .i_wb_rd(wb_rd), .i_wb_regwrite(wb_regwrite),
      .i_halt_req(halt_req), .o_halt_ack(halt_ack),
      .o_pc_en(pc_en), .o_dbuf_en(dbuf_en),
      .o_dbuf_flush(dbuf_flush), .o_ebuf_flush(ebuf_flush),
      .o_fwd_rs1(fwd_rs1), .o_fwd_rs2(fwd_rs2), .o_state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_inputs();
      {id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd} = '0;
      {id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, ex_redirect} = '0;
      {mem_regwrite, wb_regwrite, halt_req} = '0;
   endtask

   function automatic bit model_lu();
      if (!(ex_is_load && ex_regwrite) || ex_rd == 0) return 1'b0;
      return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
   endfunction

   function automatic logic [1:0] model_fwd(input logic [RW-1:0] rs);
      if (rs == 0) return 2'b00;
      if (mem_regwrite && mem_rd == rs) return 2'b01;
      if (wb_regwrite && wb_rd == rs) return 2'b10;
      return 2'b00;
   endfunction

   // Compare every combinational output with the rules for the current cycle.
   task automatic check_comb();
      logic [3:0] e;  // {pc_en, dbuf_en, dbuf_flush, ebuf_flush}
      if (m_mode == 2)       e = 4'b0110;
      else if (ex_redirect)  e = 4'b1111;
      else if (model_lu())   e = 4'b0001;
      else if (m_mode == 0)  e = 4'b1100;
      else                   e = 4'b0110;
      check("pc_en",      pc_en,      e[3]);
      check("dbuf_en",    dbuf_en,    e[2]);
      check("dbuf_flush", dbuf_flush, e[1]);
      check("ebuf_flush", ebuf_flush, e[0]);
      check("fwd_rs1",    fwd_rs1,    model_fwd(ex_rs1));
      check("fwd_rs2",    fwd_rs2,    model_fwd(ex_rs2));
   endtask

   // One clock: check outputs, advance the model across the edge, check state.
   task automatic run_cycle();
      bit lu;
      #1;
      check_comb();
      lu = model_lu();
      @(posedge clk);
      case (m_mode)
         0: if (halt_req && !ex_redirect) begin m_mode = 1; m_left = DEPTH; end
         1: begin
            if (!halt_req) m_mode = 0;
            else if (ex_redirect) m_left = DEPTH;
            else if (!lu) begin
               m_left--;
               if (m_left == 0) m_mode = 2;
            end
         end
         default: if (!halt_req) m_mode = 0;
      endcase
      #1;
      check("state",    state,    2'(m_mode));
      check("halt_ack", halt_ack, (m_mode == 2) ? 2'b01 : 2'b00);
   endtask

   initial begin
      int  cnt;
      bit  saw_ack;

      // reset held low with all inputs zero
      clear_inputs();
      rst_n = 1'b0;
      #3;
      check("rst_pc_en",      pc_en,      2'b01);
      check("rst_dbuf_en",    dbuf_en,    2'b01);
      check("rst_flushes",    {dbuf_flush, ebuf_flush}, 2'b00);
      check("rst_fwd",        fwd_rs1 | fwd_rs2, 2'b00);
      check("rst_state",      state,      2'b00);
      check("rst_halt_ack",   halt_ack,   2'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // load-use on rs2, then WB forwarding on the following cycle
      ex_is_load = 1; ex_regwrite = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
      #1;
      check("lu_pc_en", pc_en, 2'b00);
      check("lu_ebuf",  ebuf_flush, 2'b01);
      run_cycle();
      clear_inputs();
      ex_rs2 = 5; wb_rd = 5; wb_regwrite = 1;
      #1;
      check("wb_fwd_rs2", fwd_rs2, 2'b10);
      run_cycle();

      // load to x0 never stalls; MEM beats WB
      clear_inputs();
      ex_is_load = 1; ex_regwrite = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
      ex_rs1 = 3; mem_rd = 3; wb_rd = 3; mem_regwrite = 1; wb_regwrite = 1;
      #1;
      check("x0_no_stall", pc_en, 2'b01);
      check("mem_fwd_rs1", fwd_rs1, 2'b01);
      run_cycle();

      // redirect overrides a load-use hazard
      clear_inputs();
      ex_is_load = 1; ex_regwrite = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
      ex_redirect = 1;
      #1;
      check("redir_ctl", {pc_en, dbuf_flush}, 2'b11);
      check("redir_ebuf", ebuf_flush, 2'b01);
      run_cycle();

      // full drain to halt, then release
      clear_inputs();
      halt_req = 1;
      run_cycle();
      cnt = 0;
      while (!halt_ack && cnt < 20) begin
         cnt++;
         run_cycle();
      end
      check("drain_len", 2'(cnt), 2'(DEPTH));
      check("halted_ack", halt_ack, 2'b01);
      halt_req = 0;
      run_cycle();

      // short request aborts the drain: no acknowledge
      saw_ack = 0;
      halt_req = 1;
      run_cycle();
      run_cycle();
      halt_req = 0;
      for (int i = 0; i < 4; i++) begin
         run_cycle();
         if (halt_ack) saw_ack = 1;
      end
      check("abort_no_ack", 2'(saw_ack), 2'b00);
      check("abort_state",  state, 2'b00);

      // redirect on the third drain cycle reloads the counter
      halt_req = 1;
      run_cycle();
      run_cycle();
      run_cycle();
      ex_redirect = 1;
      run_cycle();
      ex_redirect = 0;
      cnt = 0;
      while (!halt_ack && cnt < 20) begin
         cnt++;
         run_cycle();
      end
      check("reload_len", 2'(cnt), 2'(DEPTH));

      // asynchronous reset while halted
      #2;
      rst_n = 1'b0;
      #1;
      check("async_state", state, 2'b00);
      check("async_ack",   halt_ack, 2'b00);
      m_mode = 0; m_left = 0;
      clear_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // randomized traffic with a slowly toggling halt request
      for (int i = 0; i < 400; i++) begin
         id_rs1 = RW'($urandom_range(3)); id_rs2 = RW'($urandom_range(3));
         ex_rd  = RW'($urandom_range(3)); ex_rs1 = RW'($urandom_range(3));
         ex_rs2 = RW'($urandom_range(3)); mem_rd = RW'($urandom_range(3));
         wb_rd  = RW'($urandom_range(3));
         id_use_rs1   = 1'($urandom_range(1));
         id_use_rs2   = 1'($urandom_range(1));
         ex_regwrite  = 1'($urandom_range(1));
         ex_is_load   = 1'($urandom_range(1));
         mem_regwrite = 1'($urandom_range(1));
         wb_regwrite  = 1'($urandom_range(1));
         ex_redirect  = ($urandom_range(7) == 0);
         if ($urandom_range(9) == 0) halt_req = ~halt_req;
         run_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
